// File: rtl/data_field_editor_pkg.sv
// Shared definitions for the field editor: repeat-FSM state encoding.
// The encoding is kept fixed because the display blink logic decodes it too.
package data_field_editor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FIRST  = 2'd1;
  localparam state_t ST_REPEAT = 2'd2;
  localparam state_t ST_BLOCK  = 2'd3;

endpackage

// File: rtl/data_field_editor_if.sv
// Control/data bundle between the button/RTC side and the field editor.
interface data_field_editor_if #(
  parameter int WIDTH      = 7,
  parameter int NUM_FIELDS = 3,
  parameter int SEL_W      = 2
) ();
  logic                        en;
  logic                        W_R;
  logic                        S;
  logic                        B;
  logic                        tick;
  logic [SEL_W-1:0]            field_sel;
  logic [NUM_FIELDS*WIDTH-1:0] limit_bus;
  logic                        ld;
  logic [NUM_FIELDS*WIDTH-1:0] ld_data;
  logic [NUM_FIELDS*WIDTH-1:0] fields;
  logic                        changed;

  modport master (
    output en, W_R, S, B, tick, field_sel, limit_bus, ld, ld_data,
    input  fields, changed
  );

  modport slave (
    input  en, W_R, S, B, tick, field_sel, limit_bus, ld, ld_data,
    output fields, changed
  );
endinterface

// File: rtl/data_field_editor_field_step.sv
// Combinational one-step wrap of a single field value against its limit.
module field_step #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] nxt
);
  always_comb begin
    nxt = val;
    if (up) begin
      nxt = (val >= limit) ? '0 : val + WIDTH'(1);
    end else if (down) begin
      // An out-of-range value snaps to the limit rather than decrementing.
      nxt = (val == '0 || val > limit) ? limit : val - WIDTH'(1);
    end
  end
endmodule

// File: rtl/data_field_editor.sv
// Multi-field wrap-around editor driven by up/down buttons with hold-to-repeat.
// Holds the edge registers, repeat FSM/counter, field registers and change strobe.
module data_field_editor
  import data_field_editor_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int NUM_FIELDS   = 3,
  parameter int SEL_W        = 2,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input logic                    clk,
  input logic                    rst,
  data_field_editor_if.slave     bus
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W:0] NF = (SEL_W+1)'(NUM_FIELDS);

  typedef logic [NUM_FIELDS-1:0][WIDTH-1:0] field_arr_t;

  field_arr_t        fields_q, fields_d, lim_a, ld_a;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              held_up_q, held_up_d;
  logic [SEL_W-1:0]  held_sel_q, held_sel_d;
  logic              S_q, B_q, changed_q, changed_d;
  logic              rise_s, rise_b, sel_ok, edit_ok, do_step, dir_up;
  logic              held_btn, other_btn;
  logic [SEL_W-1:0]  sel_idx;
  logic [WIDTH-1:0]  step_val;

  assign lim_a     = bus.limit_bus;
  assign ld_a      = bus.ld_data;
  assign rise_s    = bus.S & ~S_q;
  assign rise_b    = bus.B & ~B_q;
  assign sel_ok    = {1'b0, bus.field_sel} < NF;
  assign edit_ok   = bus.en & ~bus.W_R & ~bus.ld & sel_ok;
  assign sel_idx   = sel_ok ? bus.field_sel : '0;
  assign held_btn  = held_up_q ? bus.S : bus.B;
  assign other_btn = held_up_q ? bus.B : bus.S;
  // Direction is decided outside the FSM block so the step datapath has no loop through it.
  assign dir_up    = (state_q == ST_IDLE) ? rise_s : held_up_q;

  field_step #(.WIDTH(WIDTH)) u_step (
    .val   (fields_q[sel_idx]),
    .limit (lim_a[sel_idx]),
    .up    (dir_up),
    .down  (~dir_up),
    .nxt   (step_val)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    held_up_d  = held_up_q;
    held_sel_d = held_sel_q;
    fields_d   = fields_q;
    do_step    = 1'b0;
    if (bus.W_R) begin
      fields_d = '0;
      state_d  = ST_IDLE;
    end else if (bus.ld) begin
      for (int i = 0; i < NUM_FIELDS; i++) begin
        fields_d[i] = (ld_a[i] > lim_a[i]) ? lim_a[i] : ld_a[i];
      end
      state_d = ST_IDLE;
    end else if (!edit_ok) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.S && bus.B) begin
            state_d = ST_BLOCK;
          end else if (rise_s || rise_b) begin
            do_step    = 1'b1;
            held_up_d  = rise_s;
            held_sel_d = bus.field_sel;
            cnt_d      = CNT_W'(REPEAT_DELAY - 1);
            state_d    = ST_FIRST;
          end
        end
        ST_FIRST, ST_REPEAT: begin
          if (!held_btn) begin
            state_d = ST_IDLE;
          end else if (other_btn || bus.field_sel != held_sel_q) begin
            state_d = ST_BLOCK;
          end else if (bus.tick) begin
            if (cnt_q == '0) begin
              do_step = 1'b1;
              cnt_d   = CNT_W'(REPEAT_RATE - 1);
              state_d = ST_REPEAT;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          if (!bus.S && !bus.B) state_d = ST_IDLE;
        end
      endcase
      if (do_step) fields_d[sel_idx] = step_val;
    end
    changed_d = do_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fields_q   <= '0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      held_up_q  <= 1'b0;
      held_sel_q <= '0;
      S_q        <= 1'b0;
      B_q        <= 1'b0;
      changed_q  <= 1'b0;
    end else begin
      fields_q   <= fields_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      held_up_q  <= held_up_d;
      held_sel_q <= held_sel_d;
      S_q        <= bus.S;
      B_q        <= bus.B;
      changed_q  <= changed_d;
    end
  end

  assign bus.fields  = fields_q;
  assign bus.changed = changed_q;
endmodule

// File: tb/tb_data_field_editor.sv
// Directed bench for data_field_editor with short repeat timings.
module tb_data_field_editor;
  localparam int W = 7;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  data_field_editor_if #(.WIDTH(W), .NUM_FIELDS(3), .SEL_W(2)) bus ();

  data_field_editor #(
    .WIDTH(W), .NUM_FIELDS(3), .SEL_W(2), .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int fld(input int i);
    logic [3*W-1:0] v;
    v = bus.fields;
    return int'(v[i*W +: W]);
  endfunction

  task automatic press_s(input string tag);
    bus.S = 1'b1; cyc(1);
    chk({tag, "_chg"}, bus.changed, 1);
    bus.S = 1'b0; cyc(1);
  endtask

  task automatic press_b(input string tag);
    bus.B = 1'b1; cyc(1);
    chk({tag, "_chg"}, bus.changed, 1);
    bus.B = 1'b0; cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1; cyc(1);
      bus.tick = 1'b0; cyc(1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 0; bus.W_R = 0; bus.S = 0; bus.B = 0; bus.tick = 0;
    bus.field_sel = 0; bus.ld = 0; bus.ld_data = '0;
    bus.limit_bus = {7'd59, 7'd59, 7'd23};
    cyc(2);
    chk("rst_fields", int'(bus.fields), 0);
    chk("rst_chg", bus.changed, 0);
    rst = 1'b0; cyc(1);

    // Three single presses on field 1
    bus.field_sel = 1; bus.en = 1;
    for (int k = 0; k < 3; k++) begin
      press_s("up3");
      chk("up3_chg_low", bus.changed, 0);
    end
    chk("up3_f1", fld(1), 3);
    chk("up3_f0", fld(0), 0);
    chk("up3_f2", fld(2), 0);

    // Wrap at the top and bottom, then a lowered limit
    bus.ld_data = {7'd0, 7'd59, 7'd0}; bus.ld = 1; cyc(1); bus.ld = 0;
    chk("ld59_f1", fld(1), 59);
    chk("ld59_chg", bus.changed, 0);
    press_s("wrap_up");
    chk("wrap_up_f1", fld(1), 0);
    press_b("wrap_dn");
    chk("wrap_dn_f1", fld(1), 59);
    bus.limit_bus = {7'd59, 7'd10, 7'd23};
    press_b("over_lim");
    chk("over_lim_f1", fld(1), 10);
    bus.limit_bus = {7'd59, 7'd59, 7'd23};

    // Hold S on field 0 for ten ticks
    bus.field_sel = 0;
    bus.S = 1; cyc(1);
    chk("hold_press_f0", fld(0), 1);
    for (int t = 1; t <= 10; t++) begin
      bus.tick = 1; cyc(1);
      chk($sformatf("hold_chg_t%0d", t), bus.changed, (t >= 4 && t % 2 == 0) ? 1 : 0);
      bus.tick = 0; cyc(1);
    end
    chk("hold_f0", fld(0), 5);
    bus.S = 0; cyc(1);
    ticks(4);
    chk("release_f0", fld(0), 5);

    // Simultaneous rise blocks until both are released
    bus.S = 1; bus.B = 1; cyc(1);
    chk("both_chg", bus.changed, 0);
    ticks(3);
    bus.B = 0; cyc(1);
    ticks(5);
    chk("both_chg2", bus.changed, 0);
    chk("both_f0", fld(0), 5);
    bus.S = 0; cyc(1);
    bus.S = 1; cyc(1);
    chk("after_block_f0", fld(0), 6);
    bus.field_sel = 2; cyc(1);
    ticks(8);
    chk("selchg_f0", fld(0), 6);
    chk("selchg_f2", fld(2), 0);
    bus.S = 0; bus.field_sel = 0; cyc(1);

    // Bulk load with clamping, then W_R during a hold
    bus.ld_data = {7'd5, 7'd12, 7'd30}; bus.ld = 1; cyc(1); bus.ld = 0;
    chk("ld_f0", fld(0), 23);
    chk("ld_f1", fld(1), 12);
    chk("ld_f2", fld(2), 5);
    chk("ld_chg", bus.changed, 0);
    bus.field_sel = 1; bus.S = 1; cyc(1);
    chk("wr_pre_f1", fld(1), 13);
    ticks(2);
    bus.W_R = 1; cyc(1);
    chk("wr_fields", int'(bus.fields), 0);
    chk("wr_chg", bus.changed, 0);
    bus.W_R = 0; cyc(1);
    ticks(6);
    chk("wr_held_f1", fld(1), 0);
    bus.S = 0; cyc(1);
    press_s("wr_repress");
    chk("wr_repress_f1", fld(1), 1);

    // Editing disabled or field index out of range
    bus.en = 0; bus.S = 1; cyc(1);
    chk("en0_chg", bus.changed, 0);
    bus.S = 0; cyc(1);
    chk("en0_f1", fld(1), 1);
    bus.en = 1; bus.field_sel = 3; bus.S = 1; cyc(1);
    chk("sel3_chg", bus.changed, 0);
    bus.S = 0; cyc(1);
    chk("sel3_fields", int'(bus.fields), {7'd0, 7'd1, 7'd0});

    // Zero limit keeps the field at zero but still strobes
    bus.limit_bus = {7'd0, 7'd59, 7'd23}; bus.field_sel = 2;
    press_s("lim0_up");
    chk("lim0_up_f2", fld(2), 0);
    press_b("lim0_dn");
    chk("lim0_dn_f2", fld(2), 0);
    bus.limit_bus = {7'd59, 7'd59, 7'd23};

    // Reset while repeating
    bus.field_sel = 1; bus.S = 1; cyc(1);
    chk("rstrep_press_f1", fld(1), 2);
    ticks(4);
    chk("rstrep_first_f1", fld(1), 3);
    bus.tick = 1; rst = 1; cyc(1);
    chk("rstrep_fields", int'(bus.fields), 0);
    chk("rstrep_chg", bus.changed, 0);
    rst = 0; bus.tick = 0; bus.S = 0; cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
